// File: rtl/frame_tx_scheduler_if.sv
// frame_tx_scheduler_if
//   Groups the packetizer slot handshake, the segment descriptor, the BRAM read port and the
//   beat-aligned pixel strobes that leave the frame transmit scheduler.
//   master : the scheduler. It drives everything except tx_ack.
//   slave  : the packetizer/BRAM side. It drives tx_ack.
//   Signals:
//     tx_req    packet slot request        tx_ack    slot grant
//     seg_base  first address of segment   seg_idx   segment index
//     frame_id  frame counter              rd_en     BRAM read enable
//     rd_addr   BRAM read address          pix_valid BRAM data valid
//     pix_last  final beat of a segment
interface frame_tx_scheduler_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              tx_req;
  logic              tx_ack;
  logic [ADDR_W-1:0] seg_base;
  logic [15:0]       seg_idx;
  logic [7:0]        frame_id;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              pix_valid;
  logic              pix_last;

  modport master (
    output tx_req,
    input  tx_ack,
    output seg_base,
    output seg_idx,
    output frame_id,
    output rd_en,
    output rd_addr,
    output pix_valid,
    output pix_last
  );

  modport slave (
    input  tx_req,
    output tx_ack,
    input  seg_base,
    input  seg_idx,
    input  frame_id,
    input  rd_en,
    input  rd_addr,
    input  pix_valid,
    input  pix_last
  );
endinterface

// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler
//   Reads the downscaled frame buffer out segment by segment. Each segment first gets a
//   packet slot (tx_req/tx_ack). Then SEG_WORDS consecutive BRAM words are read, and
//   GAP_CYCLES idle cycles follow as the inter-packet gap. pix_valid/pix_last follow rd_en
//   by one cycle, which lines them up with the BRAM read data.
//   Ports:
//     clk125MHz    sole clock
//     rstb         synchronous, active-high reset
//     enable       level; low stops scheduling at the next segment boundary
//     start_frame  single-cycle frame start pulse
//     bus          frame_tx_scheduler_if.master (handshake, descriptor, read port, strobes)
//     busy         high while requesting, streaming or in the gap
//     frame_skip   one-cycle pulse for every start_frame that is ignored
//     skip_cnt     saturating count of frame_skip pulses
//                  (present only when FRAME_TX_SCHED_SKIP_CNT_EN is defined)
//   All outputs come from flops.
module frame_tx_scheduler #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned SEG_WORDS  = 320,
  parameter int unsigned NUM_SEGS   = 180,
  parameter int unsigned GAP_CYCLES = 96
) (
  input  logic                        clk125MHz,
  input  logic                        rstb,
  input  logic                        enable,
  input  logic                        start_frame,
  frame_tx_scheduler_if.master        bus,
  output logic                        busy,
  output logic                        frame_skip
`ifdef FRAME_TX_SCHED_SKIP_CNT_EN
  ,
  output logic [15:0]                 skip_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitFrame,
    StReq,
    StStream,
    StGap
  } state_e;

  localparam logic [15:0]       WordLast  = 16'(SEG_WORDS - 1);
  localparam logic [31:0]       GapLast   = 32'(GAP_CYCLES - 1);
  localparam logic [15:0]       SegLast   = 16'(NUM_SEGS - 1);
  localparam logic [ADDR_W-1:0] SegStride = ADDR_W'(SEG_WORDS);
  localparam logic [ADDR_W-1:0] AddrOne   = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [31:0]       gap_cnt_q, gap_cnt_d;
  logic [ADDR_W-1:0] seg_base_q, seg_base_d;
  logic [15:0]       seg_idx_q, seg_idx_d;
  logic [7:0]        frame_id_q, frame_id_d;
  logic              tx_req_q, tx_req_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_last_q, rd_last_d;
  logic              pix_valid_q, pix_valid_d;
  logic              pix_last_q, pix_last_d;
  logic              busy_q, busy_d;
  logic              frame_skip_q, frame_skip_d;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    seg_base_d = seg_base_q;
    seg_idx_d  = seg_idx_q;
    frame_id_d = frame_id_q;
    rd_addr_d  = rd_addr_q;

    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StWaitFrame;
      end
      StWaitFrame: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (start_frame) begin
          state_d    = StReq;
          seg_idx_d  = '0;
          seg_base_d = '0;
        end
      end
      StReq: begin
        if (bus.tx_ack) begin
          state_d    = StStream;
          word_cnt_d = '0;
          rd_addr_d  = seg_base_q;
        end
      end
      StStream: begin
        if (word_cnt_q == WordLast) begin
          state_d   = StGap;
          gap_cnt_d = '0;
        end else begin
          word_cnt_d = word_cnt_q + 16'd1;
          rd_addr_d  = rd_addr_q + AddrOne;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          if (seg_idx_q == SegLast) begin
            frame_id_d = frame_id_q + 8'd1;
            seg_idx_d  = '0;
            seg_base_d = '0;
            state_d    = enable ? StWaitFrame : StIdle;
          end else begin
            // Disabling here abandons the frame; frame_id stays as it is.
            seg_idx_d  = seg_idx_q + 16'd1;
            seg_base_d = seg_base_q + SegStride;
            state_d    = enable ? StReq : StIdle;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // The output flops load from next-state values, so each one is aligned with the state.
    tx_req_d     = (state_d == StReq);
    rd_en_d      = (state_d == StStream);
    rd_last_d    = rd_en_d && (word_cnt_d == WordLast);
    pix_valid_d  = rd_en_q;
    pix_last_d   = rd_last_q;
    busy_d       = (state_d == StReq) || (state_d == StStream) || (state_d == StGap);
    // Only an accepted start in WAIT_FRAME is not a skip. A start that arrives together
    // with enable low is ignored.
    frame_skip_d = start_frame && !((state_q == StWaitFrame) && enable);
  end

  always_ff @(posedge clk125MHz) begin
    if (rstb) begin
      state_q      <= StIdle;
      word_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      seg_base_q   <= '0;
      seg_idx_q    <= '0;
      frame_id_q   <= '0;
      tx_req_q     <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_last_q    <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_skip_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      seg_base_q   <= seg_base_d;
      seg_idx_q    <= seg_idx_d;
      frame_id_q   <= frame_id_d;
      tx_req_q     <= tx_req_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      rd_last_q    <= rd_last_d;
      pix_valid_q  <= pix_valid_d;
      pix_last_q   <= pix_last_d;
      busy_q       <= busy_d;
      frame_skip_q <= frame_skip_d;
    end
  end

`ifdef FRAME_TX_SCHED_SKIP_CNT_EN
  logic [15:0] skip_cnt_q, skip_cnt_d;

  always_comb begin
    skip_cnt_d = skip_cnt_q;
    if (frame_skip_q && (skip_cnt_q != 16'hFFFF)) skip_cnt_d = skip_cnt_q + 16'd1;
  end

  always_ff @(posedge clk125MHz) begin
    if (rstb) skip_cnt_q <= '0;
    else      skip_cnt_q <= skip_cnt_d;
  end

  assign skip_cnt = skip_cnt_q;
`endif

  assign bus.tx_req    = tx_req_q;
  assign bus.seg_base  = seg_base_q;
  assign bus.seg_idx   = seg_idx_q;
  assign bus.frame_id  = frame_id_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_last  = pix_last_q;
  assign busy          = busy_q;
  assign frame_skip    = frame_skip_q;

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Testbench for frame_tx_scheduler with small parameters: SEG_WORDS=4, NUM_SEGS=3 and
// GAP_CYCLES=2. The stimulus pushes the expected read beats into queues. A monitor running
// on the falling edge pops those beats and compares them with what the DUT presents.
module tb_frame_tx_scheduler;
  localparam int unsigned AW = 16;
  localparam int unsigned SW = 4;
  localparam int unsigned NS = 3;
  localparam int unsigned GC = 2;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] base;
    logic [15:0] idx;
    logic [7:0]  fid;
  } rd_exp_t;

  logic clk;
  logic rstb;
  logic enable;
  logic start_frame;
  logic busy;
  logic frame_skip;
`ifdef FRAME_TX_SCHED_SKIP_CNT_EN
  logic [15:0] skip_cnt;
`endif

  frame_tx_scheduler_if #(.ADDR_W(AW)) bus ();

  frame_tx_scheduler #(
    .ADDR_W    (AW),
    .SEG_WORDS (SW),
    .NUM_SEGS  (NS),
    .GAP_CYCLES(GC)
  ) dut (
    .clk125MHz  (clk),
    .rstb       (rstb),
    .enable     (enable),
    .start_frame(start_frame),
    .bus        (bus),
    .busy       (busy),
    .frame_skip (frame_skip)
`ifdef FRAME_TX_SCHED_SKIP_CNT_EN
    ,
    .skip_cnt   (skip_cnt)
`endif
  );

  int      n_cmp;
  int      n_fail;
  int      cyc;
  int      ack_mode;  // 0: tx_ack tied high, 1: grant on the 6th cycle of each request
  rd_exp_t rd_q[$];
  bit      pix_q[$];

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seg(input int s, input logic [7:0] fid);
    rd_exp_t e;
    for (int w = 0; w < int'(SW); w++) begin
      e.addr = 16'(s * int'(SW) + w);
      e.base = 16'(s * int'(SW));
      e.idx  = 16'(s);
      e.fid  = fid;
      rd_q.push_back(e);
      pix_q.push_back(w == int'(SW) - 1);
    end
  endtask

  task automatic pulse_start();
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      tick();
      n++;
    end
    chk("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] fid);
    for (int s = 0; s < int'(NS); s++) push_seg(s, fid);
    pulse_start();
    wait_idle(200);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tx_req"}, {31'd0, bus.tx_req}, 32'd0);
    chk({tag, "_rd_en"}, {31'd0, bus.rd_en}, 32'd0);
    chk({tag, "_pix_valid"}, {31'd0, bus.pix_valid}, 32'd0);
    chk({tag, "_pix_last"}, {31'd0, bus.pix_last}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_frame_skip"}, {31'd0, frame_skip}, 32'd0);
    chk({tag, "_rd_addr"}, {16'd0, bus.rd_addr}, 32'd0);
    chk({tag, "_seg_base"}, {16'd0, bus.seg_base}, 32'd0);
    chk({tag, "_seg_idx"}, {16'd0, bus.seg_idx}, 32'd0);
    chk({tag, "_frame_id"}, {24'd0, bus.frame_id}, 32'd0);
`ifdef FRAME_TX_SCHED_SKIP_CNT_EN
    chk({tag, "_skip_cnt"}, {16'd0, skip_cnt}, 32'd0);
`endif
  endtask

  // Watches one request phase: it must last exp_len cycles, hold seg_base and show no reads.
  task automatic watch_req(input logic [15:0] exp_base, input int exp_len);
    int n   = 0;
    int len = 0;
    int bad = 0;
    int rds = 0;
    while (!bus.tx_req && n < 60) begin
      tick();
      n++;
    end
    chk("req_seen", {31'd0, bus.tx_req}, 32'd1);
    while (bus.tx_req && len < 60) begin
      if (bus.seg_base !== exp_base) bad++;
      if (bus.rd_en) rds++;
      tick();
      len++;
    end
    chk("req_len", len, exp_len);
    chk("req_seg_base_stable", bad, 0);
    chk("no_rd_before_ack", rds, 0);
  endtask

  // tx_ack responder
  initial begin
    int req_cnt = 0;
    bus.tx_ack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ack_mode == 0) begin
        bus.tx_ack = 1'b1;
      end else if (bus.tx_req) begin
        req_cnt++;
        bus.tx_ack = (req_cnt == 6);
      end else begin
        req_cnt    = 0;
        bus.tx_ack = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    rd_exp_t e;
    bit      l;
    forever begin
      @(negedge clk);
      if (bus.rd_en === 1'b1) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_rd_en", {16'd0, bus.rd_addr}, 32'hFFFF_FFFF);
        end else begin
          e = rd_q.pop_front();
          chk("rd_addr", {16'd0, bus.rd_addr}, {16'd0, e.addr});
          chk("seg_base", {16'd0, bus.seg_base}, {16'd0, e.base});
          chk("seg_idx", {16'd0, bus.seg_idx}, {16'd0, e.idx});
          chk("frame_id", {24'd0, bus.frame_id}, {24'd0, e.fid});
        end
      end
      if (bus.pix_valid === 1'b1) begin
        if (pix_q.size() == 0) begin
          chk("unexpected_pix_valid", 32'd1, 32'd0);
        end else begin
          l = pix_q.pop_front();
          chk("pix_last", {31'd0, bus.pix_last}, {31'd0, l});
        end
      end else if (bus.pix_last === 1'b1) begin
        chk("pix_last_without_valid", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    int          first;
    int          n;
    int          hits;
    int          lasts[$];
    logic [7:0]  exp_fid;
    n_cmp       = 0;
    n_fail      = 0;
    cyc         = 0;
    ack_mode    = 0;
    rstb        = 1'b1;
    enable      = 1'b0;
    start_frame = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rstb = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    chk("wait_frame_not_busy", {31'd0, busy}, 32'd0);

    // One frame with the grant tied high.
    for (int s = 0; s < int'(NS); s++) push_seg(s, 8'd0);
    pulse_start();
    chk("tx_req_after_start", {31'd0, bus.tx_req}, 32'd1);
    first = -1;
    n = 0;
    while (busy && n < 80) begin
      if (bus.rd_en && first < 0) first = cyc;
      if (bus.pix_last) lasts.push_back(cyc);
      tick();
      n++;
    end
    chk("pix_last_count", lasts.size(), NS);
    // pix_last comes SEG_WORDS cycles after the first read of its segment, i.e. 1 cycle
    // after segment 0's final read. Segments are REQ + SEG_WORDS + GAP_CYCLES cycles apart.
    for (int k = 0; k < lasts.size() && k < int'(NS); k++)
      chk("pix_last_timing", lasts[k] - first, int'(SW) + k * (1 + int'(SW) + int'(GC)));
    chk("frame_id_after_f0", {24'd0, bus.frame_id}, 32'd1);
    chk("seg_idx_after_f0", {16'd0, bus.seg_idx}, 32'd0);
    chk("busy_after_f0", {31'd0, busy}, 32'd0);

    // Grant delayed by 5 cycles per segment.
    ack_mode = 1;
    for (int s = 0; s < int'(NS); s++) push_seg(s, 8'd1);
    pulse_start();
    for (int s = 0; s < int'(NS); s++) watch_req(16'(s * int'(SW)), 6);
    wait_idle(100);
    chk("frame_id_after_f1", {24'd0, bus.frame_id}, 32'd2);
    ack_mode = 0;

    // start_frame during segment 1 is skipped, and the frame still completes.
    for (int s = 0; s < int'(NS); s++) push_seg(s, 8'd2);
    pulse_start();
    n = 0;
    while (!(bus.rd_en && bus.seg_idx == 16'd1) && n < 60) begin
      tick();
      n++;
    end
    chk("reached_seg1_stream", {31'd0, bus.rd_en}, 32'd1);
    pulse_start();
    chk("frame_skip_stream", {31'd0, frame_skip}, 32'd1);
    tick();
    chk("frame_skip_one_cycle", {31'd0, frame_skip}, 32'd0);
    wait_idle(100);
    chk("frame_id_after_f2", {24'd0, bus.frame_id}, 32'd3);
    hits = 0;
    repeat (15) begin
      if (bus.tx_req) hits++;
      tick();
    end
    chk("no_restart_after_skip", hits, 0);
`ifdef FRAME_TX_SCHED_SKIP_CNT_EN
    chk("skip_cnt_one", {16'd0, skip_cnt}, 32'd1);
`endif

    // enable dropped during segment 0: segment 0 finishes, then the block goes idle.
    push_seg(0, 8'd3);
    pulse_start();
    n = 0;
    while (!bus.rd_en && n < 30) begin
      tick();
      n++;
    end
    enable = 1'b0;
    wait_idle(60);
    chk("frame_id_abandoned", {24'd0, bus.frame_id}, 32'd3);
    hits = 0;
    repeat (15) begin
      if (bus.tx_req) hits++;
      tick();
    end
    chk("no_req_when_disabled", hits, 0);
    pulse_start();
    chk("frame_skip_idle", {31'd0, frame_skip}, 32'd1);
    tick();
`ifdef FRAME_TX_SCHED_SKIP_CNT_EN
    chk("skip_cnt_two", {16'd0, skip_cnt}, 32'd2);
`endif

    // Reset on the 3rd read of a segment.
    enable = 1'b1;
    tick();
    tick();
    push_seg(0, 8'd3);
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.rd_en && bus.rd_addr == 16'd2) && n < 40);
    chk("reached_third_read", {16'd0, bus.rd_addr}, 32'd2);
    rstb = 1'b1;
    tick();
    check_zero("mid_stream_reset");
    rd_q.delete();
    pix_q.delete();
    rstb = 1'b0;
    tick();
    tick();
    run_frame(8'd0);
    chk("frame_id_after_reset_frame", {24'd0, bus.frame_id}, 32'd1);

    // frame_id wraps 255 -> 0
    exp_fid = 8'd1;
    for (int i = 0; i < 255; i++) begin
      if (i == 254) chk("frame_id_255", {24'd0, bus.frame_id}, 32'd255);
      run_frame(exp_fid);
      exp_fid = exp_fid + 8'd1;
    end
    chk("frame_id_wrap", {24'd0, bus.frame_id}, 32'd0);

    tick();
    tick();
    chk("rd_queue_drained", rd_q.size(), 0);
    chk("pix_queue_drained", pix_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
